// File: rtl/router_switch_alloc.sv
// rtl/router_switch_alloc.sv - switch allocator and crossbar sequencer for the mesh router
// Per-output round-robin arbiters with wormhole locking; invalid destinations are drained.
module router_switch_alloc #(
  parameter int NUM_PORTS = 5,
  parameter int SEL_W     = 3
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [NUM_PORTS-1:0]       in_vld,
  input  logic [NUM_PORTS*SEL_W-1:0] in_dst,
  input  logic [NUM_PORTS-1:0]       in_last,
  input  logic [NUM_PORTS-1:0]       out_rdy,
  output logic [NUM_PORTS*SEL_W-1:0] xbar_sel,
  output logic [NUM_PORTS-1:0]       xbar_en,
  output logic [NUM_PORTS-1:0]       in_pop,
  output logic [NUM_PORTS-1:0]       out_busy,
  output logic [NUM_PORTS-1:0]       err_drop
);

  typedef enum logic [1:0] {IN_FREE = 2'd0, IN_GRANTED = 2'd1, IN_DROP = 2'd2} in_state_t;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_LOCK = 1'b1} out_state_t;

  // One extra bit so the limit is representable even when 2**SEL_W == NUM_PORTS.
  localparam logic [SEL_W:0] PORT_LIMIT = (SEL_W+1)'(NUM_PORTS);

  in_state_t        in_state  [NUM_PORTS];
  out_state_t       out_state [NUM_PORTS];
  logic [SEL_W-1:0] owner     [NUM_PORTS];
  logic [SEL_W-1:0] ptr       [NUM_PORTS];
  logic [SEL_W-1:0] dst       [NUM_PORTS];
  logic [SEL_W-1:0] winner    [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand  [NUM_PORTS];
  logic [NUM_PORTS-1:0] bad_dst;
  logic [NUM_PORTS-1:0] free;
  logic [NUM_PORTS-1:0] found;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dst[i]     = in_dst[i*SEL_W +: SEL_W];
      bad_dst[i] = {1'b0, dst[i]} >= PORT_LIMIT;
      free[i]    = in_state[i] == IN_FREE;
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand[o][i] = in_vld[i] & free[i] & (dst[i] == SEL_W'(o));
      end
    end
  end

  // Scan from ptr+1 upward with wrap; the first hit wins.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      found[o]  = 1'b0;
      winner[o] = '0;
      if (out_state[o] == OUT_IDLE) begin
        for (int k = 1; k <= NUM_PORTS; k++) begin
          idx = (int'(ptr[o]) + k) % NUM_PORTS;
          if (!found[o] && cand[o][idx]) begin
            found[o]  = 1'b1;
            winner[o] = SEL_W'(idx);
          end
        end
      end
    end
  end

  always_comb begin
    xbar_en = '0;
    in_pop  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (out_state[o] == OUT_LOCK) begin
        xbar_en[o] = in_vld[owner[o]] & out_rdy[o];
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (xbar_en[o]) begin
        in_pop[owner[o]] = 1'b1;
      end
    end
    // Dropped packets drain regardless of any output readiness.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_state[i] == IN_DROP && in_vld[i]) begin
        in_pop[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      xbar_sel[o*SEL_W +: SEL_W] = owner[o];
      out_busy[o]                = out_state[o] == OUT_LOCK;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_drop <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_state[o] <= OUT_IDLE;
        owner[o]     <= '0;
        ptr[o]       <= SEL_W'(NUM_PORTS - 1);
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        in_state[i] <= IN_FREE;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        case (out_state[o])
          OUT_IDLE: begin
            if (found[o]) begin
              out_state[o] <= OUT_LOCK;
              owner[o]     <= winner[o];
              ptr[o]       <= winner[o];
            end
          end
          OUT_LOCK: begin
            if (xbar_en[o] && in_last[owner[o]]) begin
              out_state[o] <= OUT_IDLE;
            end
          end
          default: out_state[o] <= OUT_IDLE;
        endcase
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        err_drop[i] <= 1'b0;
        case (in_state[i])
          IN_FREE: begin
            if (found[dst[i]] && winner[dst[i]] == SEL_W'(i) && !bad_dst[i]) begin
              in_state[i] <= IN_GRANTED;
            end else if (in_vld[i] && bad_dst[i]) begin
              in_state[i] <= IN_DROP;
              err_drop[i] <= 1'b1;
            end
          end
          IN_GRANTED, IN_DROP: begin
            if (in_pop[i] && in_last[i]) begin
              in_state[i] <= IN_FREE;
            end
          end
          default: in_state[i] <= IN_FREE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_router_switch_alloc.sv
// tb/tb_router_switch_alloc.sv - randomized scoreboard bench for router_switch_alloc
// A packet-level reference model predicts every output each cycle; a monitor compares.
module tb_router_switch_alloc;
  localparam int N    = 5;
  localparam int SW   = 3;
  localparam int NCYC = 1600;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [N-1:0]    in_vld = '0;
  logic [N*SW-1:0] in_dst = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    out_rdy = '0;
  logic [N*SW-1:0] xbar_sel;
  logic [N-1:0]    xbar_en, in_pop, out_busy, err_drop;

  router_switch_alloc #(.NUM_PORTS(N), .SEL_W(SW)) dut (
    .clk(clk), .arst(arst), .in_vld(in_vld), .in_dst(in_dst), .in_last(in_last),
    .out_rdy(out_rdy), .xbar_sel(xbar_sel), .xbar_en(xbar_en), .in_pop(in_pop),
    .out_busy(out_busy), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] dst;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [N-1:0]    en;
    logic [N-1:0]    pop;
    logic [N-1:0]    busy;
    logic [N-1:0]    err;
    logic [N*SW-1:0] sel;
  } exp_t;

  beat_t fifo [N][$];
  exp_t  sb [$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: owner = -1 means the output is free; input mode 0 free, 1 forwarding, 2 discarding.
  int           m_owner [N];
  int           m_rr    [N];
  int           m_sel   [N];
  int           m_mode  [N];
  logic [N-1:0] m_err;
  logic [N-1:0] cur_v, cur_l, cur_r;
  int           cur_d [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_owner[k] = -1;
      m_rr[k]    = N - 1;
      m_sel[k]   = 0;
      m_mode[k]  = 0;
    end
    m_err = '0;
  endtask

  task automatic model_cycle(output exp_t e);
    int win [N];
    int old_mode [N];
    int c;
    e = '0;
    for (int o = 0; o < N; o++) begin
      if (m_owner[o] >= 0 && cur_v[m_owner[o]] && cur_r[o]) begin
        e.en[o] = 1'b1;
        e.pop[m_owner[o]] = 1'b1;
      end
      e.busy[o] = m_owner[o] >= 0;
      e.sel[o*SW +: SW] = SW'(m_sel[o]);
    end
    for (int i = 0; i < N; i++) begin
      if (m_mode[i] == 2 && cur_v[i]) e.pop[i] = 1'b1;
      old_mode[i] = m_mode[i];
    end
    e.err = m_err;
    for (int o = 0; o < N; o++) begin
      win[o] = -1;
      if (m_owner[o] < 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_rr[o] + k) % N;
          if (win[o] < 0 && cur_v[c] && old_mode[c] == 0 && cur_d[c] == o) win[o] = c;
        end
      end
    end
    m_err = '0;
    for (int o = 0; o < N; o++) begin
      if (e.en[o] && cur_l[m_owner[o]]) m_owner[o] = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (old_mode[i] != 0 && e.pop[i] && cur_l[i]) m_mode[i] = 0;
      if (old_mode[i] == 0 && cur_v[i] && cur_d[i] >= N) begin
        m_mode[i] = 2;
        m_err[i]  = 1'b1;
      end
    end
    for (int o = 0; o < N; o++) begin
      if (win[o] >= 0) begin
        m_owner[o]      = win[o];
        m_rr[o]         = win[o];
        m_sel[o]        = win[o];
        m_mode[win[o]]  = 1;
      end
    end
  endtask

  task automatic add_packet(input int i, input int d, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.dst  = (b == 0) ? SW'(d) : SW'($urandom_range(0, 7));
      bt.last = (b == len - 1);
      fifo[i].push_back(bt);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("xbar_en",  32'(xbar_en),  32'(e.en));
      check("in_pop",   32'(in_pop),   32'(e.pop));
      check("out_busy", 32'(out_busy), 32'(e.busy));
      check("err_drop", 32'(err_drop), 32'(e.err));
      check("xbar_sel", 32'(xbar_sel), 32'(e.sel));
    end
  end

  initial begin
    exp_t e;
    logic rst_now;
    int   phase;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      rst_now = (cyc < 2) || (cyc == 1100) || (cyc == 1101);
      arst    = rst_now;
      phase   = (cyc < 500) ? 0 : (cyc < 900) ? 1 : 2;
      if (cyc == 3) begin
        add_packet(0, 2, 3);
      end else if (!rst_now && cyc > 12) begin
        for (int i = 0; i < N; i++) begin
          if (phase == 1) begin
            if ((i == 0 || i == 1 || i == 3) && fifo[i].size() < 3) add_packet(i, 4, 1);
          end else if (fifo[i].size() < 6 && $urandom_range(0, 99) < (phase == 0 ? 30 : 50)) begin
            add_packet(i,
                       ($urandom_range(0, 9) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N - 1),
                       $urandom_range(1, phase == 0 ? 4 : 6));
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (fifo[i].size() > 0) begin
          cur_v[i] = (cyc < 12 || phase == 1) ? 1'b1 : ($urandom_range(0, 7) != 0);
          cur_d[i] = int'(fifo[i][0].dst);
          cur_l[i] = fifo[i][0].last;
        end else begin
          cur_v[i] = 1'b0;
          cur_d[i] = $urandom_range(0, 7);
          cur_l[i] = 1'($urandom_range(0, 1));
        end
        in_dst[i*SW +: SW] = SW'(cur_d[i]);
        cur_r[i] = (cyc < 12 || phase == 1) ? 1'b1 :
                   (phase == 0) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      end
      in_vld  = cur_v;
      in_last = cur_l;
      out_rdy = cur_r;
      if (rst_now) begin
        model_reset();
        e = '0;
        sb.push_back(e);
        for (int i = 0; i < N; i++) fifo[i].delete();
      end else begin
        model_cycle(e);
        sb.push_back(e);
        for (int i = 0; i < N; i++) begin
          if (e.pop[i]) void'(fifo[i].pop_front());
        end
      end
    end
    @(posedge clk);
    #6;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_switch_alloc.md
Name: router_switch_alloc

Overview:
- Switch allocator and crossbar sequencer for the mesh router.
- Sits between the per-port input FIFOs and output FIFOs.
- Each output port runs its own round-robin arbiter over input heads that target it.
- A grant is locked for a whole packet (wormhole) until its last beat is transferred.
- Drives crossbar select and enable lines, and input FIFO pops. Also drops packets whose destination is invalid.

Parameters:
- NUM_PORTS, 5, number of router ports (N, W, E, S, NI; NI is index NUM_PORTS-1); legal range 3..5.
- SEL_W, 3, width of one port index; must satisfy 2**SEL_W >= NUM_PORTS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- arst  in  1  reset, asynchronous, active-high.
- in_vld  in  NUM_PORTS  input FIFO i has a head beat (not empty).
- in_dst  in  NUM_PORTS*SEL_W  destination port of head beat i, slice [i*SEL_W +: SEL_W]; only meaningful on a header beat.
- in_last  in  NUM_PORTS  head beat i is the last beat of its packet.
- out_rdy  in  NUM_PORTS  output FIFO o can accept a beat (not full).
- xbar_sel  out  NUM_PORTS*SEL_W  per output o, index of the input routed to it.
- xbar_en  out  NUM_PORTS  per output o, a beat is written to output FIFO o this cycle.
- in_pop  out  NUM_PORTS  pop input FIFO i this cycle.
- out_busy  out  NUM_PORTS  output o is locked to a packet.
- err_drop  out  NUM_PORTS  one-cycle pulse: input i began dropping a packet with dst >= NUM_PORTS.

Behaviour:

Reset (arst high, asynchronous):
- All output FSMs go to IDLE; all input FSMs go to FREE.
- xbar_sel = 0, xbar_en = 0, in_pop = 0, out_busy = 0, err_drop = 0.
- RR pointer of every output = NUM_PORTS-1, so input 0 has highest priority first.
- Reset mid-packet abandons the lock; no beat is popped in or after the reset cycle.

Input FSM (per input i):
- States: FREE, GRANTED, DROP.
- FREE -> DROP when in_vld[i] and dst >= NUM_PORTS. err_drop[i] pulses on the cycle of the transition (registered).
- FREE -> GRANTED when selected by an output arbiter (same edge as that output enters LOCK).
- In DROP: in_pop[i] = in_vld[i], without regard to any out_rdy. Return to FREE after the pop where in_last[i] = 1.
- In GRANTED: return to FREE on the edge after the owning output transfers the beat with in_last[i] = 1.

Output FSM (per output o):
- States: IDLE, LOCK; owner register of SEL_W bits.
- IDLE candidates: inputs with in_vld, input FSM in FREE, and in_dst == o. Self-route (dst == i) is legal.
- Arbitration: pick the first candidate scanning from ptr+1 upward, with wrap-around.
- On that edge: owner <= winner; ptr <= winner; state <= LOCK.
- No candidates: stay IDLE.

In LOCK:
- xbar_sel[o] = owner.
- xbar_en[o] = in_vld[owner] & out_rdy[o].
- in_pop[owner] = xbar_en[o].
- A transfer with in_last[owner] returns the output to IDLE next cycle; ptr is unchanged since it was set at grant.
- in_vld low or out_rdy low: hold, no transfer, no timeout.

Other output rules:
- In IDLE, xbar_en = 0 and xbar_sel holds its last value.
- out_busy[o] = (state == LOCK).

Timing:
- Grant is registered. A header present in cycle t transfers no earlier than t+1.
- A single-beat packet occupies an output for 2 cycles.
- After a last beat at cycle t, a new header on the same input can be arbitrated at t+1 and transfer at t+2.

Conflict rules:
- An input has one head destination, so at most one output can select a FREE input per cycle. No input-side conflict logic is needed.
- in_pop and xbar_en are combinational from state and inputs; everything else is registered.

Test Plan:
1. Single packet: input 0 header with dst=2, 3 beats, last on beat 3, out_rdy=1 -> out_busy[2] rises at cycle 1. xbar_en[2] and in_pop[0] are high cycles 1..3 with xbar_sel[2]=0. out_busy[2] falls at cycle 4.
2. Round-robin fairness: inputs 0, 1, 3 stream 1-beat packets to dst=4 -> grant order 0, 1, 3, 0, 1, 3. Each packet takes 2 cycles; no input is starved.
3. Wormhole lock: input 1 sends a 4-beat packet to dst=0; input 2 raises a header to dst=0 at beat 2 -> input 2 is not granted until the cycle after input 1's last beat. No interleaving on output 0.
4. Backpressure: out_rdy[3]=0 for 5 cycles mid-packet -> xbar_en[3]=0 and in_pop=0 during those cycles. Transfer resumes the cycle out_rdy returns; beat count is preserved.
5. Bad destination: input 4 header with dst=6 (NUM_PORTS=5), 3 beats -> err_drop[4] pulses once. in_pop[4] is high for 3 cycles with out_rdy all 0. No xbar_en is asserted.
6. Parallel and reset: inputs 0->1 and 2->3 run concurrently -> both transfer every cycle. arst asserted mid-packet -> all outputs are 0 that cycle; after release, input 0 wins first on a contested output.
